// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath: instruction
// fields and ALU flags flow in, mux selects and write enables flow out.
interface multicycle_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUControl;
    logic [3:0]  State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
        output ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
        input  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: FSM sequencing, ALU decode, NZCV flag
// storage and condition-gated architectural writes.
module multicycle_controller #(
    parameter bit UNDEF_TRAP = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic [5:0]  w_funct;
    logic [3:0]  w_rd;
    logic        w_unused_rn;

    logic [3:0]  w_flags;
    logic        w_cond_ex;
    logic [1:0]  w_alu_dec_ctl;
    logic [1:0]  w_flag_w;
    logic        w_exec;
    logic        w_flag_upd;

    logic        w_next_pc;
    logic        w_branch;
    logic        w_reg_w;
    logic        w_mem_w;
    logic        w_ir_write;
    logic        w_adr_src;
    logic [1:0]  w_alu_src_a;
    logic [1:0]  w_alu_src_b;
    logic [1:0]  w_result_src;
    logic [1:0]  w_alu_control;
    logic        w_pcs;

    // Instr carries bits [31:12] of the instruction word, so field positions are offset by 12.
    assign w_cond      = bus.Instr[19:16];
    assign w_op        = bus.Instr[15:14];
    assign w_funct     = bus.Instr[13:8];
    assign w_rd        = bus.Instr[3:0];
    assign w_unused_rn = ^bus.Instr[7:4];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = S_FETCH;
        w_next_pc     = 1'b0;
        w_branch      = 1'b0;
        w_reg_w       = 1'b0;
        w_mem_w       = 1'b0;
        w_ir_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_result_src  = 2'b00;
        w_alu_control = 2'b00;
        w_exec        = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_state_next  = S_DECODE;
                w_ir_write    = 1'b1;
                w_next_pc     = 1'b1;
                w_alu_src_a   = 2'b01;
                w_alu_src_b   = 2'b10;
                w_result_src  = 2'b10;
            end
            S_DECODE: begin
                w_alu_src_a   = 2'b01;
                w_alu_src_b   = 2'b10;
                w_result_src  = 2'b10;
                case (w_op)
                    2'b00:   w_state_next = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_state_next = S_MEMADR;
                    2'b10:   w_state_next = S_BRANCH;
                    default: w_state_next = UNDEF_TRAP ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_b   = 2'b01;
                w_state_next  = w_funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_adr_src     = 1'b1;
                w_state_next  = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src  = 2'b01;
                w_reg_w       = 1'b1;
                w_state_next  = S_FETCH;
            end
            S_MEMWR: begin
                w_adr_src     = 1'b1;
                w_mem_w       = 1'b1;
                w_state_next  = S_FETCH;
            end
            S_EXECUTER: begin
                w_alu_control = w_alu_dec_ctl;
                w_exec        = 1'b1;
                w_state_next  = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alu_src_b   = 2'b01;
                w_alu_control = w_alu_dec_ctl;
                w_exec        = 1'b1;
                w_state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_w       = 1'b1;
                w_state_next  = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_result_src  = 2'b10;
                w_branch      = 1'b1;
                w_state_next  = S_FETCH;
            end
            S_HALT: begin
                w_state_next  = S_HALT;
            end
            default: begin
                w_state_next  = S_FETCH;
            end
        endcase
    end

    // Unrecognised data-processing opcodes fall back to ADD, which also enables the CV update.
    always_comb begin
        w_alu_dec_ctl = 2'b00;
        case (w_funct[4:1])
            4'b0100: w_alu_dec_ctl = 2'b00;
            4'b0010: w_alu_dec_ctl = 2'b01;
            4'b0000: w_alu_dec_ctl = 2'b10;
            4'b1100: w_alu_dec_ctl = 2'b11;
            default: w_alu_dec_ctl = 2'b00;
        endcase
        w_flag_w[1] = w_funct[0];
        w_flag_w[0] = w_funct[0] & ~w_alu_dec_ctl[1];
    end

    always_comb begin
        logic n_f, z_f, c_f, v_f;
        {n_f, z_f, c_f, v_f} = w_flags;
        w_cond_ex = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ex = z_f;
            4'b0001: w_cond_ex = ~z_f;
            4'b0010: w_cond_ex = c_f;
            4'b0011: w_cond_ex = ~c_f;
            4'b0100: w_cond_ex = n_f;
            4'b0101: w_cond_ex = ~n_f;
            4'b0110: w_cond_ex = v_f;
            4'b0111: w_cond_ex = ~v_f;
            4'b1000: w_cond_ex = c_f & ~z_f;
            4'b1001: w_cond_ex = ~c_f | z_f;
            4'b1010: w_cond_ex = (n_f == v_f);
            4'b1011: w_cond_ex = (n_f != v_f);
            4'b1100: w_cond_ex = ~z_f & (n_f == v_f);
            4'b1101: w_cond_ex = z_f | (n_f != v_f);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign w_flag_upd = w_exec & w_cond_ex;

    // Field 1 holds NZ (flags[3:2]), field 0 holds CV (flags[1:0]); each has its own write enable.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_flag_field
            logic [1:0] r_field;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_field <= 2'b00;
                end else if (w_flag_upd && w_flag_w[gi]) begin
                    r_field <= bus.ALUFlags[2*gi+1 -: 2];
                end
            end
            assign w_flags[2*gi+1 -: 2] = r_field;
        end
    endgenerate

    assign w_pcs          = w_branch | (w_reg_w & (w_rd == 4'hF));

    assign bus.PCWrite    = w_next_pc | (w_pcs & w_cond_ex);
    assign bus.MemWrite   = w_mem_w & w_cond_ex;
    assign bus.RegWrite   = w_reg_w & w_cond_ex;
    assign bus.IRWrite    = w_ir_write;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.RegSrc     = {(w_op == 2'b01), (w_op == 2'b10)};
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ImmSrc     = w_op;
    assign bus.ALUControl = w_alu_control;
    assign bus.State      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: a driver walks instruction paths from an instruction-level
// model and queues expected outputs; a monitor compares both DUT variants each cycle.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        tb_reset;
    logic [19:0] tb_instr;
    logic [3:0]  tb_aluflags;

    always #5 clk = ~clk;

    multicycle_controller_if bus_t();
    multicycle_controller_if bus_n();

    assign bus_t.Instr    = tb_instr;
    assign bus_t.ALUFlags = tb_aluflags;
    assign bus_n.Instr    = tb_instr;
    assign bus_n.ALUFlags = tb_aluflags;

    multicycle_controller #(.UNDEF_TRAP(1'b1)) dut_t (.clk(clk), .reset(tb_reset), .bus(bus_t));
    multicycle_controller #(.UNDEF_TRAP(1'b0)) dut_n (.clk(clk), .reset(tb_reset), .bus(bus_n));

    typedef struct packed {
        logic [20:0] t;
        logic [20:0] n;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn    = 0;
    logic [3:0]  m_flags;
    exp_t        mon_e;
    logic [20:0] act_t, act_n;

    assign act_t = {bus_t.PCWrite, bus_t.MemWrite, bus_t.RegWrite, bus_t.IRWrite, bus_t.AdrSrc,
                    bus_t.RegSrc, bus_t.ALUSrcA, bus_t.ALUSrcB, bus_t.ResultSrc, bus_t.ImmSrc,
                    bus_t.ALUControl, bus_t.State};
    assign act_n = {bus_n.PCWrite, bus_n.MemWrite, bus_n.RegWrite, bus_n.IRWrite, bus_n.AdrSrc,
                    bus_n.RegSrc, bus_n.ALUSrcA, bus_n.ALUSrcB, bus_n.ResultSrc, bus_n.ImmSrc,
                    bus_n.ALUControl, bus_n.State};

    // ARM condition: even codes test a predicate, odd codes invert it; 1111 never executes.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        if (c == 4'b1111) return 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic logic [1:0] alu_op(input logic [5:0] funct);
        case (funct[4:1])
            4'b0100: return 2'd0;
            4'b0010: return 2'd1;
            4'b0000: return 2'd2;
            4'b1100: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [20:0] expect_vec(input logic [3:0] st, input logic [19:0] ins,
                                               input logic [3:0] f);
        logic [1:0] op, srca, srcb, res, aluc;
        logic       nextpc, branch, regw, memw, irw, adr, ce, pcs;
        op = ins[15:14];
        ce = cond_ok(ins[19:16], f);
        {nextpc, branch, regw, memw, irw, adr} = 6'b0;
        {srca, srcb, res, aluc} = 8'b0;
        case (st)
            4'd0: begin nextpc = 1; irw = 1; srca = 2'b01; srcb = 2'b10; res = 2'b10; end
            4'd1: begin srca = 2'b01; srcb = 2'b10; res = 2'b10; end
            4'd2: srcb = 2'b01;
            4'd3: adr = 1;
            4'd4: begin res = 2'b01; regw = 1; end
            4'd5: begin adr = 1; memw = 1; end
            4'd6: aluc = alu_op(ins[13:8]);
            4'd7: begin srcb = 2'b01; aluc = alu_op(ins[13:8]); end
            4'd8: regw = 1;
            4'd9: begin srca = 2'b10; srcb = 2'b01; res = 2'b10; branch = 1; end
            default: ;
        endcase
        pcs = branch | (regw & (ins[3:0] == 4'hF));
        return {nextpc | (pcs & ce), memw & ce, regw & ce, irw, adr,
                {op == 2'b01, op == 2'b10}, srca, srcb, res, op, aluc, st};
    endfunction

    task automatic drive(input logic [19:0] ins, input logic [3:0] st_t, input logic [3:0] st_n,
                         input logic rst_v, input logic [4:0] af);
        exp_t e;
        @(posedge clk);
        #1;
        tb_instr    = ins;
        tb_aluflags = af[4] ? af[3:0] : 4'($urandom);
        tb_reset    = rst_v;
        e.t = expect_vec(st_t, ins, m_flags);
        e.n = expect_vec(st_n, ins, m_flags);
        exp_q.push_back(e);
    endtask

    // One instruction from FETCH to its last state; abort_at asserts reset in that step.
    task automatic run_instr(input logic [19:0] ins, input logic [4:0] af, input int abort_at);
        logic [3:0] path[$];
        logic [5:0] funct;
        funct = ins[13:8];
        case (ins[15:14])
            2'b00:   path = '{4'd0, 4'd1, (funct[5] ? 4'd7 : 4'd6), 4'd8};
            2'b01:   path = funct[0] ? '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4} : '{4'd0, 4'd1, 4'd2, 4'd5};
            default: path = '{4'd0, 4'd1, 4'd9};
        endcase
        for (int i = 0; i < path.size(); i++) begin
            drive(ins, path[i], path[i], (i == abort_at), af);
            if (i == abort_at) begin
                m_flags = 4'b0000;
                return;
            end
            if ((path[i] == 4'd6 || path[i] == 4'd7) && cond_ok(ins[19:16], m_flags) && funct[0]) begin
                m_flags[3:2] = tb_aluflags[3:2];
                if (alu_op(funct) < 2) m_flags[1:0] = tb_aluflags[1:0];
            end
        end
    endtask

    // Op=11: trapping copy sits in HALT, the other loops FETCH/DECODE, until a shared reset.
    task automatic run_undef(input logic [19:0] ins);
        for (int i = 0; i < 7; i++) begin
            drive(ins, (i < 2) ? 4'(i) : 4'd10, 4'(i % 2), 1'b0, 5'h00);
        end
        drive(ins, 4'd10, 4'd1, 1'b1, 5'h00);
        m_flags = 4'b0000;
    endtask

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] funct, input logic [3:0] rd);
        return {c, op, funct, 4'h1, rd};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_txn++;
            n_checks++;
            if (act_t !== mon_e.t) begin
                n_errors++;
                $display("FAIL trap_dut_outputs cycle %0d: got %h (state %0d) expected %h (state %0d)",
                         n_txn, act_t, act_t[3:0], mon_e.t, mon_e.t[3:0]);
            end
            n_checks++;
            if (act_n !== mon_e.n) begin
                n_errors++;
                $display("FAIL nop_dut_outputs cycle %0d: got %h (state %0d) expected %h (state %0d)",
                         n_txn, act_n, act_n[3:0], mon_e.n, mon_e.n[3:0]);
            end
            $display("cycle %0d: trap state=%0d out=%h | nop state=%0d out=%h",
                     n_txn, act_t[3:0], act_t, act_n[3:0], act_n);
        end
    end

    initial begin
        logic [3:0]  r_cond;
        logic [1:0]  r_op;
        logic [5:0]  r_funct;
        logic [3:0]  r_rd;
        tb_reset    = 1'b1;
        tb_instr    = 20'h0;
        tb_aluflags = 4'h0;
        m_flags     = 4'b0000;
        repeat (3) @(posedge clk);

        run_instr(mk(4'hE, 2'b00, 6'b001000, 4'h2), 5'h00, -1);  // ADD reg
        run_instr(mk(4'hE, 2'b00, 6'b100101, 4'h3), 5'h14, -1);  // SUBS imm, Z set
        run_instr(mk(4'h0, 2'b10, 6'b100000, 4'h0), 5'h00, -1);  // BEQ taken
        run_instr(mk(4'h1, 2'b10, 6'b100000, 4'h0), 5'h00, -1);  // BNE not taken
        run_instr(mk(4'hE, 2'b01, 6'b011001, 4'h4), 5'h00, -1);  // LDR
        run_instr(mk(4'hE, 2'b01, 6'b011000, 4'h4), 5'h00, -1);  // STR
        run_instr(mk(4'hE, 2'b00, 6'b001001, 4'h5), 5'h10, -1);  // ADDS, flags 0000
        run_instr(mk(4'h0, 2'b00, 6'b001000, 4'hF), 5'h1F, -1);  // ADDEQ PC skipped
        run_instr(mk(4'h0, 2'b10, 6'b100000, 4'h0), 5'h00, -1);  // BEQ not taken
        run_instr(mk(4'hE, 2'b00, 6'b100101, 4'h3), 5'h1F, -1);  // SUBS, flags 1111
        run_instr(mk(4'hE, 2'b01, 6'b011001, 4'h4), 5'h00, 3);   // LDR, reset in MEMRD
        run_instr(mk(4'h0, 2'b10, 6'b100000, 4'h0), 5'h00, -1);  // BEQ after reset: not taken
        run_instr(mk(4'h3, 2'b10, 6'b100000, 4'h0), 5'h00, -1);  // BCC after reset: taken
        run_instr(mk(4'hE, 2'b01, 6'b011001, 4'hF), 5'h00, -1);  // LDR PC
        run_undef(mk(4'hE, 2'b11, 6'b000000, 4'h0));

        for (int k = 0; k < 70; k++) begin
            r_cond  = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
            r_op    = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            r_funct = 6'($urandom);
            if (r_op == 2'b00 && $urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 3))
                    0: r_funct[4:1] = 4'b0100;
                    1: r_funct[4:1] = 4'b0010;
                    2: r_funct[4:1] = 4'b0000;
                    default: r_funct[4:1] = 4'b1100;
                endcase
            end
            r_rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            if (r_op == 2'b11) run_undef(mk(r_cond, r_op, r_funct, r_rd));
            else run_instr(mk(r_cond, r_op, r_funct, r_rd), 5'h00, -1);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
